// File: rtl/sram_ctrl.sv
// MEM-stage data memory front end: turns one 32-bit load/store into two timed
// half-word accesses on an external asynchronous 16-bit SRAM, stalling via ready.
module sram_ctrl #(
  parameter int BASE_ADDR       = 1024,
  parameter int SRAM_ADDR_WIDTH = 18,
  parameter int ACCESS_CYCLES   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic [31:0]                address,
  input  logic [31:0]                write_data,
  output logic [31:0]                read_data,
  output logic                       ready,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [15:0]                sram_dq_wr,
  input  logic [15:0]                sram_dq_rd,
  output logic                       sram_dq_oe,
  output logic                       sram_we_n,
  output logic                       sram_ce_n,
  output logic [1:0]                 dbg_state
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int WW = SRAM_ADDR_WIDTH - 1;
  localparam logic [CW-1:0] RELOAD = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  state_t                     r_state, w_state_nxt;
  logic [CW-1:0]              r_cnt, w_cnt_nxt;
  logic                       r_write, w_write_nxt;
  logic [WW-1:0]              r_word, w_word_nxt;
  logic [31:0]                r_data, w_data_nxt;
  logic [15:0]                r_low;
  logic [31:0]                r_read_data;
  logic [SRAM_ADDR_WIDTH-1:0] r_sram_addr, w_sram_addr_nxt;
  logic [15:0]                r_dq_wr, w_dq_wr_nxt;
  logic                       r_oe, w_oe_nxt;
  logic                       r_we_n, w_we_n_nxt;
  logic                       r_ce_n, w_ce_n_nxt;
  logic                       w_req, w_latch, w_cap_low, w_cap_high, w_active;
  logic [31:0]                w_offset;
  logic [WW-1:0]              w_word_in;

  assign w_req     = mem_read | mem_write;
  assign w_offset  = address - 32'(BASE_ADDR);
  assign w_word_in = WW'(w_offset >> 2);

  assign ready      = ~w_req | (r_state == S_DONE);
  assign read_data  = r_read_data;
  assign sram_addr  = r_sram_addr;
  assign sram_dq_wr = r_dq_wr;
  assign sram_dq_oe = r_oe;
  assign sram_we_n  = r_we_n;
  assign sram_ce_n  = r_ce_n;
  assign dbg_state  = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_cap_low   = 1'b0;
    w_cap_high  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_latch     = 1'b1;
          w_state_nxt = S_LOW;
          w_cnt_nxt   = RELOAD;
        end
      end
      S_LOW: begin
        if (r_cnt == '0) begin
          w_cap_low   = 1'b1;
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = RELOAD;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_HIGH: begin
        if (r_cnt == '0) begin
          w_cap_high  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Pins are computed from the next state so they can be registered glitch-free.
    w_write_nxt     = w_latch ? mem_write  : r_write;
    w_word_nxt      = w_latch ? w_word_in  : r_word;
    w_data_nxt      = w_latch ? write_data : r_data;
    w_active        = (w_state_nxt == S_LOW) || (w_state_nxt == S_HIGH);
    w_ce_n_nxt      = ~w_active;
    w_we_n_nxt      = ~(w_active & w_write_nxt);
    w_oe_nxt        = w_active & w_write_nxt;
    w_sram_addr_nxt = r_sram_addr;
    w_dq_wr_nxt     = r_dq_wr;
    if (w_active) begin
      w_sram_addr_nxt = {w_word_nxt, (w_state_nxt == S_HIGH)};
      w_dq_wr_nxt     = (w_state_nxt == S_HIGH) ? w_data_nxt[31:16] : w_data_nxt[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_word      <= '0;
      r_data      <= '0;
      r_low       <= '0;
      r_read_data <= '0;
      r_sram_addr <= '0;
      r_dq_wr     <= '0;
      r_oe        <= 1'b0;
      r_we_n      <= 1'b1;
      r_ce_n      <= 1'b1;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_write     <= w_write_nxt;
      r_word      <= w_word_nxt;
      r_data      <= w_data_nxt;
      r_sram_addr <= w_sram_addr_nxt;
      r_dq_wr     <= w_dq_wr_nxt;
      r_oe        <= w_oe_nxt;
      r_we_n      <= w_we_n_nxt;
      r_ce_n      <= w_ce_n_nxt;
      if (w_cap_low && !r_write)  r_low       <= sram_dq_rd;
      if (w_cap_high && !r_write) r_read_data <= {sram_dq_rd, r_low};
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (ACCESS_CYCLES 2 and 1), each on a small
// behavioural SRAM; directed ops are queued and checked by per-instance monitors.
module tb_sram_ctrl;

  localparam int W = 89;  // {wr[88], hbase[87:72], wdata[71:40], rdata[39:8], lat[7:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read   [2];
  logic        mem_write  [2];
  logic [31:0] address    [2];
  logic [31:0] write_data [2];
  logic [31:0] read_data  [2];
  logic        ready      [2];
  logic [17:0] sram_addr  [2];
  logic [15:0] dq_wr      [2];
  logic [15:0] dq_rd      [2];
  logic        oe         [2];
  logic        we_n       [2];
  logic        ce_n       [2];
  logic [1:0]  dbg_state  [2];
  bit   [15:0] sram_mem   [2][64];

  logic        pre_en = 1'b0;
  logic [5:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int AC = (g == 0) ? 2 : 1;
    int cyc = 0;

    sram_ctrl #(.BASE_ADDR(1024), .SRAM_ADDR_WIDTH(18), .ACCESS_CYCLES(AC)) u_dut (
      .clk(clk), .rst(rst), .mem_read(mem_read[g]), .mem_write(mem_write[g]),
      .address(address[g]), .write_data(write_data[g]), .read_data(read_data[g]),
      .ready(ready[g]), .sram_addr(sram_addr[g]), .sram_dq_wr(dq_wr[g]),
      .sram_dq_rd(dq_rd[g]), .sram_dq_oe(oe[g]), .sram_we_n(we_n[g]),
      .sram_ce_n(ce_n[g]), .dbg_state(dbg_state[g])
    );

    // Asynchronous SRAM model: combinational read, write while ce_n/we_n low.
    assign dq_rd[g] = sram_mem[g][sram_addr[g][5:0]];
    always @(posedge clk) begin
      if (g == 0 && pre_en) sram_mem[g][pre_addr] <= pre_data;
      else if (!ce_n[g] && !we_n[g]) sram_mem[g][sram_addr[g][5:0]] <= dq_wr[g];
    end

    always @(negedge clk) begin : mon
      logic [W-1:0] e;
      logic         wr, hi;
      logic [15:0]  hb;
      logic [31:0]  wd, rd;
      int           lat;
      if (!rst || !mon_en) begin
        cyc = 0;
      end else if ((mem_read[g] || mem_write[g]) && exp_q.size() > 0) begin
        e   = exp_q[0];
        wr  = e[88];
        hb  = e[87:72];
        wd  = e[71:40];
        rd  = e[39:8];
        lat = int'(e[7:0]);
        if (cyc >= 1 && cyc <= 2 * AC) begin
          hi = (cyc > AC);
          check($sformatf("d%0d_ce_n_active", g), 32'(ce_n[g]), 32'd0);
          check($sformatf("d%0d_sram_addr", g), 32'(sram_addr[g]), 32'(hb) + 32'(hi));
          check($sformatf("d%0d_we_n_active", g), 32'(we_n[g]), 32'(!wr));
          check($sformatf("d%0d_oe_active", g), 32'(oe[g]), 32'(wr));
          if (wr) check($sformatf("d%0d_dq_wr", g), 32'(dq_wr[g]), hi ? 32'(wd[31:16]) : 32'(wd[15:0]));
        end else begin
          check($sformatf("d%0d_ce_n_idle", g), 32'(ce_n[g]), 32'd1);
          check($sformatf("d%0d_we_n_idle", g), 32'(we_n[g]), 32'd1);
          check($sformatf("d%0d_oe_idle", g), 32'(oe[g]), 32'd0);
        end
        if (ready[g]) begin
          check($sformatf("d%0d_ready_cycle", g), 32'(cyc), 32'(lat));
          if (!wr) check($sformatf("d%0d_read_data", g), read_data[g], rd);
          void'(exp_q.pop_front());
          cyc = 0;
        end else begin
          if (cyc >= lat) check($sformatf("d%0d_ready_missing", g), 32'(ready[g]), 32'd1);
          cyc++;
        end
      end
    end
  end

  // Issue one request at the start of a cycle and hold it until ready is seen.
  task automatic op(input int d, input bit wr, input bit rd, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic [15:0] hb,
                    input logic [31:0] rdata, input int lat, input bit keep);
    int n;
    mem_write[d]  = wr;
    mem_read[d]   = rd;
    address[d]    = addr;
    write_data[d] = wdata;
    exp_q.push_back({wr, hb, wdata, rdata, 8'(lat)});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready[d] && n < 40);
    if (!ready[d]) begin
      checks++;
      errors++;
      $display("FAIL op_timeout: dut %0d ready still 0 after %0d cycles, expected 1", d, n);
      void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      mem_write[d] = 1'b0;
      mem_read[d]  = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_read[i] = 1'b0; mem_write[i] = 1'b0; address[i] = '0; write_data[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Reset state
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_ready%0d", i), 32'(ready[i]), 32'd1);
      check($sformatf("rst_we_n%0d", i), 32'(we_n[i]), 32'd1);
      check($sformatf("rst_ce_n%0d", i), 32'(ce_n[i]), 32'd1);
      check($sformatf("rst_oe%0d", i), 32'(oe[i]), 32'd0);
      check($sformatf("rst_read_data%0d", i), read_data[i], 32'd0);
      check($sformatf("rst_sram_addr%0d", i), 32'(sram_addr[i]), 32'd0);
    end

    // Preload SRAM half-words 4/5 for the read test
    @(posedge clk); #1;
    pre_en = 1'b1; pre_addr = 6'd4; pre_data = 16'h5678;
    @(posedge clk); #1;
    pre_addr = 6'd5; pre_data = 16'h1234;
    @(posedge clk); #1;
    pre_en = 1'b0;
    mon_en = 1'b1;

    // Single write and single read with AC=2
    op(0, 1, 0, 32'd1024, 32'hDEADBEEF, 16'd0, 32'h0, 5, 0);
    op(0, 0, 1, 32'd1032, 32'h0,        16'd4, 32'h12345678, 5, 0);
    repeat (2) @(posedge clk); #1;

    // Back-to-back ops with the request held; both-set is a write
    op(0, 1, 0, 32'd1024, 32'hCAFEF00D, 16'd0, 32'h0, 5, 1);
    op(0, 0, 1, 32'd1024, 32'h0,        16'd0, 32'hCAFEF00D, 5, 1);
    op(0, 1, 1, 32'd1040, 32'hA5A51234, 16'd8, 32'h0, 5, 1);
    op(0, 0, 1, 32'd1040, 32'h0,        16'd8, 32'hA5A51234, 5, 0);
    repeat (2) @(posedge clk); #1;

    // Reset during the HIGH phase of a write
    mon_en = 1'b0;
    mem_write[0] = 1'b1; address[0] = 32'd1048; write_data[0] = 32'h11112222;
    repeat (3) @(posedge clk);
    #1;
    check("high_we_n_before_rst", 32'(we_n[0]), 32'd0);
    check("high_state_before_rst", 32'(dbg_state[0]), 32'd2);
    check("high_sram_addr_before_rst", 32'(sram_addr[0]), 32'd13);
    #1 rst = 1'b0;
    #1;
    check("abort_we_n", 32'(we_n[0]), 32'd1);
    check("abort_ce_n", 32'(ce_n[0]), 32'd1);
    check("abort_oe", 32'(oe[0]), 32'd0);
    check("abort_state", 32'(dbg_state[0]), 32'd0);
    check("abort_read_data", read_data[0], 32'd0);
    mem_write[0] = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    op(0, 0, 1, 32'd1032, 32'h0, 16'd4, 32'h12345678, 5, 0);

    // ACCESS_CYCLES=1 instance, byte-offset bits ignored
    op(1, 1, 0, 32'd1024, 32'h0BADF00D, 16'd0, 32'h0, 3, 0);
    op(1, 0, 1, 32'd1027, 32'h0,        16'd0, 32'h0BADF00D, 3, 0);
    op(1, 1, 0, 32'd1031, 32'h600DCAFE, 16'd2, 32'h0, 3, 1);
    op(1, 0, 1, 32'd1028, 32'h0,        16'd2, 32'h600DCAFE, 3, 0);

    repeat (3) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("read_data_held", read_data[0], 32'h12345678);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
